shift_rotate_seq: RTL and testbench
===================================

// Module: shift_rotate_seq
// PURPOSE
//  Upstream sequencer and consumer for the 16-bit rotate-left barrel mux in the 8088 ALU shift/rotate path.
//  It accepts an 8088 group-2 op (ROL/ROR/RCL/RCR/SHL/SHR/SAR), a byte/word operand and a count, and drives the mux.
//  It then masks the mux output into the final result, produces CF/OF, and returns them with a start/done handshake.
//  ROL/ROR/SHL/SHR/SAR take one barrel pass; RCL/RCR iterate one bit per cycle (17/9-bit rotation is beyond the mux).
// PARAMETERS
//  none (datapath fixed at 16 bits, count fixed at 8 bits, as on the 8088)
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   synchronous, active-high reset
//  start    in   1   request; sampled only when busy=0
//  OP       in   3   000 ROL,001 ROR,010 RCL,011 RCR,100 SHL,101 SHR,110 SHL(SAL),111 SAR
//  W        in   1   1=word, 0=byte (operand in A[7:0])
//  A        in   16  operand
//  CNT      in   8   shift/rotate count (CL or 1); not masked
//  CF_in    in   1   carry flag before the op
//  MUX_A    out  16  operand to rotate-left mux
//  MUX_OP   out  4   left-rotate amount to mux
//  MUX_R    in   16  mux result (combinational from MUX_A/MUX_OP)
//  R        out  16  result; byte mode R[15:8]=0
//  CF       out  1   carry flag out
//  OF       out  1   overflow flag out
//  flags_we out  1   1 = CF/OF valid to write (0 when CNT==0)
//  busy     out  1   op in progress
//  done     out  1   one-cycle pulse, R/CF/OF/flags_we valid
// BEHAVIOUR
//  Reset: state IDLE; R=0, CF=0, OF=0, flags_we=0, busy=0, done=0, MUX_A=0, MUX_OP=0.
//  Inputs A/OP/W/CNT/CF_in are latched on accepted start; later changes are ignored.
//  FSM states: IDLE, BARREL, ITER, DONE.
//   IDLE: start=1 goes to BARREL (ROL/ROR/SHx/SAR, or CNT==0 for any op) else ITER; busy=1 from the next cycle.
//   BARREL: one cycle; mux driven, result/flags registered; goes to DONE.
//   ITER: k = CNT mod 17 (word) / mod 9 (byte); one-bit rotate-through-carry per cycle for k cycles, then DONE.
//   ITER with k=0 behaves as one BARREL cycle with R=A, CF=CF_in.
//   DONE: done=1 and busy=0 for one cycle; outputs hold until the next accepted start.
//  Latency from start to done: 2 cycles for barrel ops; k+2 cycles for RCL/RCR with k>0.
//  start while busy=1 or done=1 is ignored (not queued).
//  Byte mode: MUX_A={A[7:0],A[7:0]}; low byte of MUX_R taken.
//  Mux amount: n = CNT mod width. ROL uses MUX_OP = n; ROR uses MUX_OP = (16-n) mod 16.
//  Shifts: rotate, then zero-fill (SHL low n bits, SHR high n bits) or sign-fill (SAR high n bits).
//  Shift count >= width: SHL/SHR give R=0; SHL/SHR with CNT==width give CF = A[0] / A[msb]; CNT>width gives CF=0.
//   SAR with CNT >= width gives R=all sign bits, CF=sign.
//  CF: last bit shifted/rotated out. ROL: CF=R[0]. ROR: CF=R[msb].
//  OF when CNT==1: ROL/RCL/SHL = R[msb]^CF; ROR/RCR = R[msb]^R[msb-1]; SHR = A[msb]; SAR = 0. OF=0 when CNT!=1.
//  CNT==0: R=A (byte-masked), CF=CF_in, OF=0, flags_we=0; still 2-cycle latency.
//  rst mid-op: state goes to IDLE at that edge, all outputs take reset values; the op is abandoned with no done.
// TESTING
//  ROL W=1 A=16'h8001 CNT=1 -> done at start+2, R=16'h0003, CF=1, OF=1, flags_we=1.
//  RCL W=1 A=16'h8000 CF_in=0 CNT=2 -> busy for 3 cycles, done at start+4, R=16'h0001, CF=0, OF=0.
//  SAR W=0 A=16'h0080 CNT=10 -> R=16'h00FF, CF=1, OF=0; ROR W=0 A=8'h01 CNT=1 -> R=16'h0080, CF=1, OF=1.
//  SHL W=1 A=16'h0001 CNT=16 -> R=0, CF=1; same with CNT=17 -> R=0, CF=0.
//  Any OP, CNT=0, A=16'h1234, CF_in=1 -> R=16'h1234, CF=1, flags_we=0, done at start+2.
//  RCR W=1 CNT=16 started, second start pulsed while busy -> ignored; rst at iteration 5 -> next cycle busy=0, done=0, R=0.

Source files
------------

// File: rtl/shift_rotate_seq_if.sv
// Handshake, operand/result and barrel-mux signals of the 8088 shift/rotate sequencer.
// The slave side is the sequencer; the master side is the requester plus the rotate-left mux.
interface shift_rotate_seq_if;
    logic        start;
    logic [2:0]  OP;
    logic        W;
    logic [15:0] A;
    logic [7:0]  CNT;
    logic        CF_in;
    logic [15:0] MUX_A;
    logic [3:0]  MUX_OP;
    logic [15:0] MUX_R;
    logic [15:0] R;
    logic        CF;
    logic        OF;
    logic        flags_we;
    logic        busy;
    logic        done;

    modport slave (
        input  start, OP, W, A, CNT, CF_in, MUX_R,
        output MUX_A, MUX_OP, R, CF, OF, flags_we, busy, done
    );

    modport master (
        output start, OP, W, A, CNT, CF_in, MUX_R,
        input  MUX_A, MUX_OP, R, CF, OF, flags_we, busy, done
    );
endinterface

// File: rtl/shift_rotate_seq.sv
// 8088 group-2 shift/rotate sequencer: drives an external 16-bit rotate-left mux for single-pass ops
// and iterates RCL/RCR one bit per cycle, returning R/CF/OF with a start/done handshake.
module shift_rotate_seq (
    input  logic              clk,
    input  logic              rst,
    shift_rotate_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BARREL = 2'd1,
        S_ITER   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_RCL = 3'd2;
    localparam logic [2:0] OP_RCR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SAL = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        w_q, w_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] work_q, work_d;
    logic        wcf_q, wcf_d;
    logic [4:0]  k_q, k_d;
    logic [15:0] mux_a_q, mux_a_d;
    logic [3:0]  mux_op_q, mux_op_d;
    logic [15:0] r_q, r_d;
    logic        cf_q, cf_d;
    logic        of_q, of_d;
    logic        we_q, we_d;

    logic        accept_s, rc_in_s;
    logic [3:0]  n_in_s, n_s;
    logic [15:0] wmask_s, rot_s, lowm_s, highm_s, fill_s;
    logic        sign_s, ge_w_s, eq_w_s;
    logic [15:0] bar_r_s, step_r_s;
    logic        bar_cf_s, bar_of_s, step_cf_s;

    function automatic logic msb_of(input logic [15:0] v, input logic w);
        return w ? v[15] : v[7];
    endfunction

    function automatic logic msb1_of(input logic [15:0] v, input logic w);
        return w ? v[14] : v[6];
    endfunction

    // Through-carry rotation spans width+1 bits, so the count wraps at 17 (word) or 9 (byte).
    function automatic logic [4:0] rc_count(input logic [7:0] c, input logic w);
        return 5'(w ? c % 8'd17 : c % 8'd9);
    endfunction

    assign accept_s = (state_q == S_IDLE) && bus.start;
    assign rc_in_s  = (bus.OP == OP_RCL) || (bus.OP == OP_RCR);
    assign n_in_s   = bus.W ? bus.CNT[3:0] : {1'b0, bus.CNT[2:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (rc_in_s && (bus.CNT != 8'd0)) ? S_ITER : S_BARREL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BARREL: state_d = S_DONE;
            S_ITER:   state_d = (k_q == 5'd0) ? S_DONE : S_ITER;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Barrel pass: the mux output is a rotation; shifts then zero- or sign-fill the vacated bits.
    always_comb begin
        n_s      = w_q ? cnt_q[3:0] : {1'b0, cnt_q[2:0]};
        wmask_s  = w_q ? 16'hFFFF : 16'h00FF;
        rot_s    = bus.MUX_R & wmask_s;
        lowm_s   = (16'd1 << n_s) - 16'd1;
        highm_s  = wmask_s & ~(wmask_s >> n_s);
        sign_s   = msb_of(work_q, w_q);
        fill_s   = sign_s ? wmask_s : 16'h0000;
        ge_w_s   = cnt_q >= (w_q ? 8'd16 : 8'd8);
        eq_w_s   = cnt_q == (w_q ? 8'd16 : 8'd8);
        bar_r_s  = rot_s;
        bar_cf_s = rot_s[0];
        case (op_q)
            OP_ROL: begin
                bar_r_s  = rot_s;
                bar_cf_s = rot_s[0];
            end
            OP_ROR: begin
                bar_r_s  = rot_s;
                bar_cf_s = msb_of(rot_s, w_q);
            end
            OP_SHL, OP_SAL: begin
                if (ge_w_s) begin
                    bar_r_s  = 16'h0000;
                    bar_cf_s = eq_w_s & work_q[0];
                end else begin
                    bar_r_s  = rot_s & ~lowm_s;
                    bar_cf_s = rot_s[0];
                end
            end
            OP_SHR: begin
                if (ge_w_s) begin
                    bar_r_s  = 16'h0000;
                    bar_cf_s = eq_w_s & sign_s;
                end else begin
                    bar_r_s  = rot_s & ~highm_s;
                    bar_cf_s = msb_of(rot_s, w_q);
                end
            end
            OP_SAR: begin
                if (ge_w_s) begin
                    bar_r_s  = fill_s;
                    bar_cf_s = sign_s;
                end else begin
                    bar_r_s  = (rot_s & ~highm_s) | (fill_s & highm_s);
                    bar_cf_s = msb_of(rot_s, w_q);
                end
            end
            default: begin
                bar_r_s  = work_q;
                bar_cf_s = wcf_q;
            end
        endcase
        if (cnt_q == 8'd1) begin
            case (op_q)
                OP_ROL, OP_SHL, OP_SAL: bar_of_s = msb_of(bar_r_s, w_q) ^ bar_cf_s;
                OP_ROR:                 bar_of_s = msb_of(bar_r_s, w_q) ^ msb1_of(bar_r_s, w_q);
                OP_SHR:                 bar_of_s = sign_s;
                default:                bar_of_s = 1'b0;
            endcase
        end else begin
            bar_of_s = 1'b0;
        end
    end

    // One rotate-through-carry step.
    always_comb begin
        if (op_q == OP_RCR) begin
            step_cf_s = work_q[0];
            step_r_s  = (work_q >> 1) | (wcf_q ? (w_q ? 16'h8000 : 16'h0080) : 16'h0000);
        end else begin
            step_cf_s = msb_of(work_q, w_q);
            step_r_s  = ((work_q << 1) | {15'd0, wcf_q}) & wmask_s;
        end
    end

    // Datapath next state: latch on accept, finish a barrel pass, or iterate.
    always_comb begin
        op_d     = op_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        wcf_d    = wcf_q;
        k_d      = k_q;
        mux_a_d  = mux_a_q;
        mux_op_d = mux_op_q;
        r_d      = r_q;
        cf_d     = cf_q;
        of_d     = of_q;
        we_d     = we_q;
        if (accept_s) begin
            op_d    = bus.OP;
            w_d     = bus.W;
            cnt_d   = bus.CNT;
            wcf_d   = bus.CF_in;
            work_d  = bus.W ? bus.A : {8'h00, bus.A[7:0]};
            k_d     = rc_count(bus.CNT, bus.W);
            mux_a_d = bus.W ? bus.A : {bus.A[7:0], bus.A[7:0]};
            case (bus.OP)
                OP_ROR, OP_SHR, OP_SAR: mux_op_d = 4'd0 - n_in_s;
                default:                mux_op_d = n_in_s;
            endcase
        end else if (state_q == S_BARREL) begin
            if (cnt_q == 8'd0) begin
                r_d  = work_q;
                cf_d = wcf_q;
                of_d = 1'b0;
                we_d = 1'b0;
            end else begin
                r_d  = bar_r_s;
                cf_d = bar_cf_s;
                of_d = bar_of_s;
                we_d = 1'b1;
            end
        end else if (state_q == S_ITER) begin
            if (k_q != 5'd0) begin
                work_d = step_r_s;
                wcf_d  = step_cf_s;
                k_d    = k_q - 5'd1;
            end else begin
                r_d  = work_q;
                cf_d = wcf_q;
                we_d = 1'b1;
                if (cnt_q == 8'd1) begin
                    of_d = (op_q == OP_RCR) ? (msb_of(work_q, w_q) ^ msb1_of(work_q, w_q))
                                            : (msb_of(work_q, w_q) ^ wcf_q);
                end else begin
                    of_d = 1'b0;
                end
            end
        end else begin
            r_d = r_q;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 3'd0;
            w_q      <= 1'b0;
            cnt_q    <= 8'd0;
            work_q   <= 16'h0000;
            wcf_q    <= 1'b0;
            k_q      <= 5'd0;
            mux_a_q  <= 16'h0000;
            mux_op_q <= 4'd0;
            r_q      <= 16'h0000;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            op_q     <= op_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            wcf_q    <= wcf_d;
            k_q      <= k_d;
            mux_a_q  <= mux_a_d;
            mux_op_q <= mux_op_d;
            r_q      <= r_d;
            cf_q     <= cf_d;
            of_q     <= of_d;
            we_q     <= we_d;
        end
    end

    // Output decode.
    always_comb begin
        bus.busy     = (state_q == S_BARREL) || (state_q == S_ITER);
        bus.done     = (state_q == S_DONE);
        bus.MUX_A    = mux_a_q;
        bus.MUX_OP   = mux_op_q;
        bus.R        = r_q;
        bus.CF       = cf_q;
        bus.OF       = of_q;
        bus.flags_we = we_q;
    end
endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: models the rotate-left mux and checks every op against a
// bit-at-a-time 8088 reference, including latency, ignored starts and mid-op reset.
module tb_shift_rotate_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    shift_rotate_seq_if bus_if ();

    shift_rotate_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mux_rotl(input logic [15:0] a, input logic [3:0] n);
        logic [31:0] t;
        t = {a, a} << n;
        return t[31:16];
    endfunction

    assign bus_if.MUX_R = mux_rotl(bus_if.MUX_A, bus_if.MUX_OP);

    // Reference: apply the op one bit at a time, CNT times, exactly as the instruction is defined.
    task automatic ref_model(input logic [2:0] op, input logic w, input logic [15:0] a,
                             input logic [7:0] cnt, input logic cf_in,
                             output logic [15:0] r, output logic cf, output logic of,
                             output logic we, output int lat);
        int          msb;
        logic [15:0] mask, v, a0;
        logic        c, nc, sign;
        msb  = w ? 15 : 7;
        mask = w ? 16'hFFFF : 16'h00FF;
        a0   = a & mask;
        v    = a0;
        c    = cf_in;
        sign = v[msb];
        for (int i = 0; i < int'(cnt); i++) begin
            case (op)
                3'd0: begin c = v[msb]; v = ((v << 1) | {15'd0, c}) & mask; end
                3'd1: begin c = v[0]; v = v >> 1; v[msb] = c; end
                3'd2: begin nc = v[msb]; v = ((v << 1) | {15'd0, c}) & mask; c = nc; end
                3'd3: begin nc = v[0]; v = v >> 1; v[msb] = c; c = nc; end
                3'd5: begin c = v[0]; v = v >> 1; end
                3'd7: begin c = v[0]; v = v >> 1; v[msb] = sign; end
                default: begin c = v[msb]; v = (v << 1) & mask; end
            endcase
        end
        r  = v;
        cf = c;
        of = 1'b0;
        if (cnt == 8'd1) begin
            case (op)
                3'd1, 3'd3: of = r[msb] ^ r[msb-1];
                3'd5:       of = a0[msb];
                3'd7:       of = 1'b0;
                default:    of = r[msb] ^ c;
            endcase
        end
        we  = (cnt != 8'd0);
        lat = 2;
        if ((op == 3'd2 || op == 3'd3) && cnt != 8'd0) lat = (int'(cnt) % (w ? 17 : 9)) + 2;
    endtask

    // One operation; optionally pulse start while busy (cycle poke) or during done.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [15:0] a,
                          input logic [7:0] cnt, input logic cf_in, input int poke,
                          input bit poke_done, input string tag);
        logic [15:0] er, emux_a;
        logic [3:0]  emux_op;
        logic        ecf, eof, ewe;
        int          elat, lat, n;
        ref_model(op, w, a, cnt, cf_in, er, ecf, eof, ewe, elat);
        n       = w ? int'(cnt) % 16 : int'(cnt) % 8;
        emux_a  = w ? a : {a[7:0], a[7:0]};
        emux_op = (op == 3'd1) ? 4'((16 - n) % 16) : 4'(n);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.OP = op; bus_if.W = w; bus_if.A = a;
        bus_if.CNT = cnt; bus_if.CF_in = cf_in;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.OP = 3'($urandom); bus_if.W = 1'($urandom); bus_if.A = 16'($urandom);
        bus_if.CNT = 8'($urandom); bus_if.CF_in = 1'($urandom);
        lat = 1;
        while (bus_if.done !== 1'b1 && lat < 40) begin
            checks++;
            if (bus_if.busy !== 1'b1) begin
                errors++; $display("FAIL %s busy cyc %0d got %b exp 1", tag, lat, bus_if.busy);
            end
            if (lat == 1 && op != 3'd2 && op != 3'd3 && cnt != 8'd0) begin
                checks++;
                if (bus_if.MUX_A !== emux_a) begin
                    errors++; $display("FAIL %s MUX_A got %h exp %h", tag, bus_if.MUX_A, emux_a);
                end
                if (op == 3'd0 || op == 3'd1) begin
                    checks++;
                    if (bus_if.MUX_OP !== emux_op) begin
                        errors++; $display("FAIL %s MUX_OP got %0d exp %0d", tag, bus_if.MUX_OP, emux_op);
                    end
                end
            end
            bus_if.start = (lat == poke) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != elat) begin
            errors++; $display("FAIL %s latency got %0d exp %0d", tag, lat, elat);
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL %s busy at done got %b exp 0", tag, bus_if.busy);
        end
        checks++;
        if (bus_if.R !== er || bus_if.CF !== ecf || bus_if.OF !== eof || bus_if.flags_we !== ewe) begin
            errors++;
            $display("FAIL %s op=%0d w=%b a=%h cnt=%0d cfi=%b got R=%h CF=%b OF=%b WE=%b exp R=%h CF=%b OF=%b WE=%b",
                     tag, op, w, a, cnt, cf_in, bus_if.R, bus_if.CF, bus_if.OF, bus_if.flags_we,
                     er, ecf, eof, ewe);
        end
        bus_if.start = poke_done ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.R !== er || bus_if.CF !== ecf) begin
            errors++;
            $display("FAIL %s hold got done=%b busy=%b R=%h CF=%b exp done=0 busy=0 R=%h CF=%b",
                     tag, bus_if.done, bus_if.busy, bus_if.R, bus_if.CF, er, ecf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.OP = 3'd0; bus_if.W = 1'b1;
        bus_if.A = 16'hFFFF; bus_if.CNT = 8'd3; bus_if.CF_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.R !== 16'h0000 || bus_if.CF !== 1'b0 || bus_if.OF !== 1'b0 ||
            bus_if.flags_we !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 ||
            bus_if.MUX_A !== 16'h0000 || bus_if.MUX_OP !== 4'd0) begin
            errors++;
            $display("FAIL reset got R=%h CF=%b OF=%b WE=%b busy=%b done=%b MUX_A=%h MUX_OP=%0d exp all 0",
                     bus_if.R, bus_if.CF, bus_if.OF, bus_if.flags_we, bus_if.busy, bus_if.done,
                     bus_if.MUX_A, bus_if.MUX_OP);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(3'd0, 1'b1, 16'h8001, 8'd1,  1'b0, 0, 1'b0, "rol_8001");
        run_op(3'd2, 1'b1, 16'h8000, 8'd2,  1'b0, 0, 1'b0, "rcl_8000");
        run_op(3'd7, 1'b0, 16'h0080, 8'd10, 1'b0, 0, 1'b0, "sar_byte");
        run_op(3'd1, 1'b0, 16'h0001, 8'd1,  1'b0, 0, 1'b0, "ror_byte");
        run_op(3'd4, 1'b1, 16'h0001, 8'd16, 1'b0, 0, 1'b0, "shl_16");
        run_op(3'd4, 1'b1, 16'h0001, 8'd17, 1'b0, 0, 1'b0, "shl_17");
        run_op(3'd5, 1'b1, 16'h8000, 8'd16, 1'b0, 0, 1'b0, "shr_16");
        run_op(3'd3, 1'b0, 16'h00A5, 8'd9,  1'b1, 0, 1'b0, "rcr_k0");
        for (int o = 0; o < 8; o++) begin
            run_op(3'(o), 1'b1, 16'h1234, 8'd0, 1'b1, 0, 1'b0, "cnt0_w");
            run_op(3'(o), 1'b0, 16'h1234, 8'd0, 1'b1, 0, 1'b0, "cnt0_b");
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'd3, 1'b1, 16'h5A3C, 8'd16, 1'b1, 3, 1'b1, "rcr_poke");
        run_op(3'd6, 1'b1, 16'hC001, 8'd1,  1'b0, 1, 1'b1, "sal_poke");
        run_op(3'd2, 1'b0, 16'h0081, 8'd8,  1'b1, 5, 1'b0, "rcl_poke");
    endtask

    task automatic test_random();
        logic [7:0] picks [10];
        logic [7:0] cnt;
        picks = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9, 8'd15, 8'd16, 8'd17, 8'd255};
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(1) == 0) cnt = picks[$urandom_range(9)];
            else cnt = 8'($urandom_range(255));
            run_op(3'($urandom_range(7)), 1'($urandom_range(1)), 16'($urandom), cnt,
                   1'($urandom_range(1)), ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   ($urandom_range(3) == 0), "rand");
        end
    endtask

    task automatic test_reset_midop();
        bit saw;
        run_op(3'd0, 1'b1, 16'h8001, 8'd1, 1'b0, 0, 1'b0, "pre_rst");
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.OP = 3'd3; bus_if.W = 1'b1;
        bus_if.A = 16'hBEEF; bus_if.CNT = 8'd16; bus_if.CF_in = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.R !== 16'h0003) begin
            errors++; $display("FAIL midop got busy=%b R=%h exp busy=1 R=0003", bus_if.busy, bus_if.R);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.R !== 16'h0000 ||
            bus_if.CF !== 1'b0 || bus_if.flags_we !== 1'b0 || bus_if.MUX_A !== 16'h0000) begin
            errors++;
            $display("FAIL rst_midop got busy=%b done=%b R=%h CF=%b WE=%b MUX_A=%h exp all 0",
                     bus_if.busy, bus_if.done, bus_if.R, bus_if.CF, bus_if.flags_we, bus_if.MUX_A);
        end
        saw = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++; $display("FAIL abandoned op got activity=%b exp 0", saw);
        end
        run_op(3'd1, 1'b1, 16'h0001, 8'd4, 1'b0, 0, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
